// File: rtl/reg_write_arbiter_pkg.sv
// Shared sizing constants and requester indices for the register-file
// write-port arbiter and its pick logic.
package reg_write_arbiter_pkg;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 3;
   localparam int NUM_REGS = 2 ** ADDR_W;
   localparam int NUM_REQ  = 3;
   localparam int PTR_W    = $clog2(NUM_REQ);

   // Fixed requester slots in the packed request vectors
   localparam int REQ_ALU  = 0;
   localparam int REQ_MEM  = 1;
   localparam int REQ_LINK = 2;

   typedef logic [PTR_W-1:0] req_idx_t;

   // Index following i, wrapping back to zero after the last requester
   function automatic req_idx_t next_idx(input req_idx_t i);
      if (int'(i) >= NUM_REQ - 1) begin
         return '0;
      end
      return req_idx_t'(int'(i) + 1);
   endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Bundle of writeback-request, register-file write and scoreboard signals.
// master = execute/memory/issue side, slave = the arbiter.
interface reg_write_arbiter_if;
   import reg_write_arbiter_pkg::*;

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        grant;
   logic                      rf_we;
   logic [ADDR_W-1:0]         rf_waddr;
   logic [DATA_W-1:0]         rf_wdata;
   logic                      claim_valid;
   logic [ADDR_W-1:0]         claim_addr;
   logic [ADDR_W-1:0]         chk_addr_a;
   logic [ADDR_W-1:0]         chk_addr_b;
   logic                      hazard_a;
   logic                      hazard_b;
   logic [NUM_REGS-1:0]       busy_mask;

   modport master (
      output req, req_addr, req_data, claim_valid, claim_addr, chk_addr_a, chk_addr_b,
      input  grant, rf_we, rf_waddr, rf_wdata, hazard_a, hazard_b, busy_mask
   );

   modport slave (
      input  req, req_addr, req_data, claim_valid, claim_addr, chk_addr_a, chk_addr_b,
      output grant, rf_we, rf_waddr, rf_wdata, hazard_a, hazard_b, busy_mask
   );

endinterface

// File: rtl/reg_write_arbiter_rr.sv
// Combinational round-robin pick: first eligible requester scanning from
// rr_ptr upward, wrapping modulo NUM_REQ.
module rr_arbiter
   import reg_write_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] eligible,
   input  req_idx_t           rr_ptr,
   output logic [NUM_REQ-1:0] winner,
   output req_idx_t           win_idx,
   output logic               any_win
);

   int cand;

   // Scan priority order starting at rr_ptr; the first hit wins
   always_comb begin
      winner  = '0;
      win_idx = '0;
      any_win = 1'b0;
      cand    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(rr_ptr) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!any_win && eligible[cand]) begin
            any_win      = 1'b1;
            win_idx      = req_idx_t'(cand);
            winner[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares the register-file write port among the writeback sources with a
// registered round-robin grant, and tracks pending writes in a per-register
// busy scoreboard for issue-stage hazard detection.
module reg_write_arbiter
   import reg_write_arbiter_pkg::*;
(
   input logic               clk,
   input logic               reset,
   reg_write_arbiter_if.slave bus
);

   logic [NUM_REQ-1:0]  grant_reg;
   logic                rf_we_reg;
   logic [ADDR_W-1:0]   rf_waddr_reg;
   logic [DATA_W-1:0]   rf_wdata_reg;
   logic [NUM_REGS-1:0] busy_reg;
   logic [NUM_REGS-1:0] busy_next;
   req_idx_t            rr_ptr_reg;

   logic [NUM_REQ-1:0]  eligible;
   logic [NUM_REQ-1:0]  winner;
   req_idx_t            win_idx;
   logic                any_win;

   logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
   logic [DATA_W-1:0]   data_arr [NUM_REQ];

   // Unpack the per-source destination address and data slices
   assign addr_arr[REQ_ALU]  = bus.req_addr[REQ_ALU*ADDR_W  +: ADDR_W];
   assign addr_arr[REQ_MEM]  = bus.req_addr[REQ_MEM*ADDR_W  +: ADDR_W];
   assign addr_arr[REQ_LINK] = bus.req_addr[REQ_LINK*ADDR_W +: ADDR_W];
   assign data_arr[REQ_ALU]  = bus.req_data[REQ_ALU*DATA_W  +: DATA_W];
   assign data_arr[REQ_MEM]  = bus.req_data[REQ_MEM*DATA_W  +: DATA_W];
   assign data_arr[REQ_LINK] = bus.req_data[REQ_LINK*DATA_W +: DATA_W];

   // The requester holding the current grant still has req high during its
   // grant cycle, so it is excluded to avoid writing the same value twice.
   assign eligible = bus.req & ~grant_reg;

   rr_arbiter u_rr_arbiter (
      .eligible (eligible),
      .rr_ptr   (rr_ptr_reg),
      .winner   (winner),
      .win_idx  (win_idx),
      .any_win  (any_win)
   );

   // Registered grant, write port and round-robin pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_reg    <= '0;
         rf_we_reg    <= 1'b0;
         rf_waddr_reg <= '0;
         rf_wdata_reg <= '0;
         rr_ptr_reg   <= '0;
      end else if (any_win) begin
         grant_reg    <= winner;
         rf_we_reg    <= 1'b1;
         rf_waddr_reg <= addr_arr[win_idx];
         rf_wdata_reg <= data_arr[win_idx];
         rr_ptr_reg   <= next_idx(win_idx);
      end else begin
         grant_reg    <= '0;
         rf_we_reg    <= 1'b0;
      end
   end

   // Per-register scoreboard update: a new claim beats a completing write,
   // since the claim represents a writer that is still outstanding.
   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
         assign busy_next[gi] =
            (bus.claim_valid && (bus.claim_addr == ADDR_W'(gi))) ? 1'b1 :
            (rf_we_reg && (rf_waddr_reg == ADDR_W'(gi)))         ? 1'b0 :
                                                                   busy_reg[gi];
      end
   endgenerate

   // Scoreboard state register
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_reg <= '0;
      end else begin
         busy_reg <= busy_next;
      end
   end

   assign bus.grant     = grant_reg;
   assign bus.rf_we     = rf_we_reg;
   assign bus.rf_waddr  = rf_waddr_reg;
   assign bus.rf_wdata  = rf_wdata_reg;
   assign bus.busy_mask = busy_reg;
   // No bypass: a register stays busy through its own write cycle
   assign bus.hazard_a  = busy_reg[bus.chk_addr_a];
   assign bus.hazard_b  = busy_reg[bus.chk_addr_b];

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized and directed bench for reg_write_arbiter, checked against a
// cycle-level behavioural model of grant order, write port and scoreboard.
module tb_reg_write_arbiter;
   import reg_write_arbiter_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   reg_write_arbiter_if bus ();

   reg_write_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Stimulus state
   bit                rq [NUM_REQ];
   logic [ADDR_W-1:0] ra [NUM_REQ];
   logic [DATA_W-1:0] rd [NUM_REQ];
   bit                cv;
   logic [ADDR_W-1:0] ca, chka, chkb;

   // Model state: who holds the grant (-1 none), write port, busy set
   int                m_ptr;
   int                m_gnt;
   bit                m_we;
   logic [ADDR_W-1:0] m_waddr;
   logic [DATA_W-1:0] m_wdata;
   bit                m_busy [NUM_REGS];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_busy_vec();
      logic [31:0] v;
      v = '0;
      for (int r = 0; r < NUM_REGS; r++) v[r] = m_busy[r];
      return v;
   endfunction

   // Push stimulus onto the bus, then check the combinational hazards
   task automatic apply_inputs();
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req[i]                       = rq[i];
         bus.req_addr[i*ADDR_W +: ADDR_W] = ra[i];
         bus.req_data[i*DATA_W +: DATA_W] = rd[i];
      end
      bus.claim_valid = cv;
      bus.claim_addr  = ca;
      bus.chk_addr_a  = chka;
      bus.chk_addr_b  = chkb;
      #1;
      check_val("hazard_a", 32'(bus.hazard_a), 32'(m_busy[chka]));
      check_val("hazard_b", 32'(bus.hazard_b), 32'(m_busy[chkb]));
   endtask

   // Advance model by one edge, clock the DUT, compare every output
   task automatic step(input bit rst_v);
      int w;
      bit nb [NUM_REGS];
      reset = rst_v;
      if (rst_v) begin
         m_ptr = 0; m_gnt = -1; m_we = 0; m_waddr = '0; m_wdata = '0;
         for (int r = 0; r < NUM_REGS; r++) m_busy[r] = 0;
      end else begin
         w = -1;
         for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = (m_ptr + k) % NUM_REQ;
            if (w < 0 && rq[i] && m_gnt != i) w = i;
         end
         nb = m_busy;
         if (m_we) nb[m_waddr] = 0;
         if (cv) nb[ca] = 1;
         m_busy = nb;
         if (w >= 0) begin
            m_we = 1; m_waddr = ra[w]; m_wdata = rd[w]; m_ptr = (w + 1) % NUM_REQ;
         end else begin
            m_we = 0;
         end
         m_gnt = w;
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_val("grant", 32'(bus.grant), (m_gnt < 0) ? 32'd0 : (32'd1 << m_gnt));
      check_val("rf_we", 32'(bus.rf_we), 32'(m_we));
      check_val("rf_waddr", 32'(bus.rf_waddr), 32'(m_waddr));
      check_val("rf_wdata", 32'(bus.rf_wdata), 32'(m_wdata));
      check_val("busy_mask", 32'(bus.busy_mask), exp_busy_vec());
      if (m_gnt >= 0)
         $display("write: src=%0d addr=%0d data=%h busy=%b", m_gnt, m_waddr, m_wdata, bus.busy_mask);
   endtask

   task automatic idle_inputs();
      for (int i = 0; i < NUM_REQ; i++) begin
         rq[i] = 0; ra[i] = '0; rd[i] = '0;
      end
      cv = 0; ca = '0; chka = '0; chkb = '0;
   endtask

   initial begin
      idle_inputs();
      m_gnt = -1; m_ptr = 0; m_we = 0; m_waddr = '0; m_wdata = '0;
      for (int r = 0; r < NUM_REGS; r++) m_busy[r] = 0;
      reset = 1'b1;
      apply_inputs();

      // Reset state
      step(1'b1);
      check_val("rst_grant", 32'(bus.grant), 32'd0);
      check_val("rst_busy", 32'(bus.busy_mask), 32'd0);

      // Reset in the middle of a grant
      rq[0] = 1; ra[0] = 3'd2; rd[0] = 16'h1111; cv = 1; ca = 3'd4;
      apply_inputs();
      step(1'b0);
      check_val("mid_grant_g", 32'(bus.grant), 32'b001);
      cv = 0;
      apply_inputs();
      step(1'b1);
      check_val("mid_rst_grant", 32'(bus.grant), 32'd0);
      check_val("mid_rst_we", 32'(bus.rf_we), 32'd0);
      check_val("mid_rst_busy", 32'(bus.busy_mask), 32'd0);
      rq[0] = 1; rq[1] = 1; rq[2] = 1;
      apply_inputs();
      step(1'b0);
      check_val("ptr_after_rst", 32'(bus.grant), 32'b001);

      // Single request held through its grant cycle
      idle_inputs(); apply_inputs(); step(1'b0);
      rq[1] = 1; ra[1] = 3'd5; rd[1] = 16'hBEEF;
      apply_inputs();
      step(1'b0);
      check_val("single_grant", 32'(bus.grant), 32'b010);
      check_val("single_we", 32'(bus.rf_we), 32'd1);
      check_val("single_addr", 32'(bus.rf_waddr), 32'd5);
      check_val("single_data", 32'(bus.rf_wdata), 32'hBEEF);
      step(1'b0);
      check_val("no_double", 32'(bus.grant), 32'd0);
      rq[1] = 0; apply_inputs(); step(1'b0);

      // All three requesting continuously from reset
      step(1'b1);
      for (int i = 0; i < NUM_REQ; i++) begin
         rq[i] = 1; ra[i] = ADDR_W'(i + 1); rd[i] = DATA_W'(16'hA000 + i);
      end
      apply_inputs();
      for (int n = 0; n < 6; n++) begin
         step(1'b0);
         check_val("rr_seq", 32'(bus.grant), 32'd1 << (n % 3));
      end

      // Wrap-around after requester 2 won
      rq[1] = 0; apply_inputs();
      step(1'b0);
      check_val("wrap_0", 32'(bus.grant), 32'b001);
      step(1'b0);
      check_val("wrap_2", 32'(bus.grant), 32'b100);

      // Scoreboard: claim r3, cleared only after its write cycle
      idle_inputs(); apply_inputs(); step(1'b0);
      cv = 1; ca = 3'd3; apply_inputs(); step(1'b0);
      cv = 0; chka = 3'd3; apply_inputs();
      check_val("sb_claim", 32'(bus.hazard_a), 32'd1);
      rq[0] = 1; ra[0] = 3'd3; rd[0] = 16'h3333; apply_inputs();
      step(1'b0);
      check_val("sb_wr_cycle_we", 32'(bus.rf_we), 32'd1);
      check_val("sb_wr_cycle", 32'(bus.hazard_a), 32'd1);
      rq[0] = 0; apply_inputs();
      step(1'b0);
      check_val("sb_cleared", 32'(bus.hazard_a), 32'd0);

      // Simultaneous claim and clear on r6
      cv = 1; ca = 3'd6; apply_inputs(); step(1'b0);
      cv = 0; rq[2] = 1; ra[2] = 3'd6; rd[2] = 16'h6666; apply_inputs();
      step(1'b0);
      check_val("sim_we", 32'(bus.rf_waddr), 32'd6);
      rq[2] = 0; cv = 1; ca = 3'd6; chkb = 3'd6; apply_inputs();
      step(1'b0);
      check_val("sim_busy6", 32'(bus.busy_mask[6]), 32'd1);
      cv = 0; apply_inputs();
      check_val("sim_hazb", 32'(bus.hazard_b), 32'd1);

      // Randomized traffic following the req/grant handshake
      idle_inputs(); apply_inputs();
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!rq[i] || m_gnt == i) begin
               rq[i] = ($urandom_range(0, 2) != 0);
               ra[i] = ADDR_W'($urandom);
               rd[i] = DATA_W'($urandom);
            end
         end
         cv   = ($urandom_range(0, 2) == 0);
         ca   = ADDR_W'($urandom);
         chka = ADDR_W'($urandom);
         chkb = ADDR_W'($urandom);
         apply_inputs();
         step($urandom_range(0, 63) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the single register-file write port among up to NUM_REQ writeback sources: ALU writeback, memory load return, and link/return-address write.
- Uses round-robin arbitration with a one-cycle registered grant.
- Keeps an 8-entry pending-write scoreboard so the issue stage can detect read-after-write hazards on 3-bit register addresses.
- Sits between the execute/memory stages and the register file.

Parameters:
- DATA_W, 16, register data width.
- ADDR_W, 3, register address width; NUM_REGS = 2**ADDR_W = 8.
- NUM_REQ, 3, number of write requesters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester write request; level; held until granted.
- req_addr  in  NUM_REQ*ADDR_W  packed destination addresses; slice i belongs to requester i.
- req_data  in  NUM_REQ*DATA_W  packed write data; slice i belongs to requester i.
- grant  out  NUM_REQ  registered one-hot grant pulse.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  ADDR_W  register-file write address.
- rf_wdata  out  DATA_W  register-file write data.
- claim_valid  in  1  issue stage reserves a destination register.
- claim_addr  in  ADDR_W  register being reserved.
- chk_addr_a  in  ADDR_W  first source register to check.
- chk_addr_b  in  ADDR_W  second source register to check.
- hazard_a  out  1  combinational: busy_mask[chk_addr_a].
- hazard_b  out  1  combinational: busy_mask[chk_addr_b].
- busy_mask  out  NUM_REGS  registered scoreboard state.

Behaviour:
- Reset, synchronous and active-high, at the edge where reset=1:
  - grant=0, rf_we=0, rf_waddr=0, rf_wdata=0, busy_mask=0, rr_ptr=0.
  - Reset overrides any in-flight grant or claim; nothing is written in the cycle after reset.
- Arbitration runs every cycle on the eligible set: eligible = req & ~grant.
  - Masking the currently-granted requester prevents a double grant while its req is still high.
  - Winner = first eligible index scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
- Latency: a request sampled at edge k produces the following in cycle k..k+1, all registered and coincident:
  - grant[w]=1;
  - rf_we=1, rf_waddr=req_addr[w], rf_wdata=req_data[w], where addr and data are sampled at edge k.
- Pointer update: on a win, rr_ptr <= (w+1) mod NUM_REQ. With no win, rr_ptr holds, rf_we=0 and grant=0.
- Handshake:
  - The requester holds req, addr and data stable until it observes grant high.
  - At the edge ending the grant cycle, it drops req or presents its next request.
  - Per-requester throughput is at most 1 write per 2 cycles; aggregate throughput is 1 write per cycle.
- rf_waddr and rf_wdata hold their last values when rf_we=0.
- Scoreboard:
  - At each edge: if claim_valid, set busy_mask[claim_addr]. If rf_we in the ending cycle, clear busy_mask[rf_waddr].
  - Claim and clear on the same address in the same edge: the set wins, because a new writer is outstanding.
  - Claiming an already-busy register leaves it busy. There is no counting; one outstanding writer per register is guaranteed by issue.
- Hazard outputs are purely combinational from registered busy_mask. There is no write-to-check bypass: the register reads busy until the edge after its write cycle.
- Register 0 is treated like every other address by this block.
- Two requesters targeting the same address are written in grant order; the later one overwrites the earlier.

Decomposition:
- Shared package: DATA_W, ADDR_W, NUM_REGS, and requester index constants REQ_ALU=0, REQ_MEM=1, REQ_LINK=2, used by the datapath wiring.
- One sub-module, rr_arbiter:
  - inputs: eligible vector and rr_ptr;
  - outputs: one-hot winner, winner index, any_win.
  - Combinational pick only; rr_ptr, the output registers and the scoreboard stay in reg_write_arbiter.

Test Plan:
- Reset mid-grant: req=3'b001 held, assert reset on the grant cycle -> the next cycle has grant=0, rf_we=0, busy_mask=0, and rr_ptr=0 on release.
- Single request: req[1]=1, addr=3'd5, data=16'hBEEF at edge k -> cycle k+1 has grant=3'b010, rf_we=1, rf_waddr=5, rf_wdata=16'hBEEF; no second grant while req[1] is held through the grant cycle.
- All three requesting continuously from reset -> grant sequence 001, 010, 100, 001, ... with no requester granted in two consecutive cycles.
- Wrap-around: after requester 2 wins, req=3'b101 -> requester 0 is granted next, then requester 2.
- Scoreboard: claim r3; check chk_addr_a=3 gives hazard_a=1 until the edge after an rf_we cycle with rf_waddr=3, then hazard_a=0.
- Simultaneous claim and clear on r6 at the same edge -> busy_mask[6] stays 1; chk_addr_b=6 gives hazard_b=1.
